// File: rtl/nibbler_control.sv
// nibbler_control -- fetch/decode/execute sequencer for the Nibbler CPU.
//
// Fetches 1- and 2-byte instructions from program ROM, drives the ALU
// control lines (notCarryIn/S/operand/notOeALU), strobes the external
// accumulator and data RAM, and keeps the carry/zero flags that the
// conditional jumps test.
//
// Ports:
//   clk_i          system clock, rising edge
//   notReset_i     asynchronous active-low reset
//   progAddr_o     program ROM address (= PC)
//   progData_i     ROM byte: [7:4] opcode, [3:0] immediate / address high
//   dataAddr_o     data RAM address {IR[3:0], addrLo}
//   dataIn_i       RAM read data
//   dataWe_o       RAM write strobe (RAM stores the ALU result on the clock edge)
//   notCarryIn_o   ALU mode bit (low only for compares)
//   S_o            ALU function select
//   operand_o      ALU B input: immediate or RAM data
//   notOeALU_o     active-low ALU result output enable onto the data bus
//   loadA_o        accumulator load strobe
//   notC_i/notZ_i  ALU flags, active low
//   carryFlag_o    stored carry, active high
//   zeroFlag_o     stored zero, active high
//   halted_o       high while in the HALT state
module nibbler_control #(
  parameter int N    = 4,
  parameter int PC_W = 12
) (
  input  logic            clk_i,
  input  logic            notReset_i,
  output logic [PC_W-1:0] progAddr_o,
  input  logic [7:0]      progData_i,
  output logic [PC_W-1:0] dataAddr_o,
  input  logic [N-1:0]    dataIn_i,
  output logic            dataWe_o,
  output logic            notCarryIn_o,
  output logic [2:0]      S_o,
  output logic [N-1:0]    operand_o,
  output logic            notOeALU_o,
  output logic            loadA_o,
  input  logic            notC_i,
  input  logic            notZ_i,
  output logic            carryFlag_o,
  output logic            zeroFlag_o,
  output logic            halted_o
);

  typedef enum logic [1:0] {
    FETCH1 = 2'd0,
    FETCH2 = 2'd1,
    EXEC   = 2'd2,
    HALT   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      ir_q, ir_d;
  logic [7:0]      addr_lo_q, addr_lo_d;
  logic            carry_q, carry_d;
  logic            zero_q, zero_d;

  logic [3:0]      op;
  logic [3:0]      imm;
  logic [3:0]      fetch_op;
  logic [PC_W-1:0] target;
  logic            jump_taken;

  assign op       = ir_q[7:4];
  assign imm      = ir_q[3:0];
  assign fetch_op = progData_i[7:4];
  // Jump target and data address share the same {IR low nibble, second byte} form.
  assign target   = PC_W'({imm, addr_lo_q});

  // Conditions use the flags as stored at the start of EXEC.
  always_comb begin
    jump_taken = 1'b0;
    case (op)
      4'hA:    jump_taken = 1'b1;
      4'hB:    jump_taken = carry_q;
      4'hC:    jump_taken = ~carry_q;
      4'hD:    jump_taken = zero_q;
      4'hE:    jump_taken = ~zero_q;
      default: jump_taken = 1'b0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    addr_lo_d = addr_lo_q;
    carry_d   = carry_q;
    zero_d    = zero_q;
    case (state_q)
      FETCH1: begin
        ir_d = progData_i;
        pc_d = pc_q + PC_W'(1);
        if (fetch_op == 4'hF)
          state_d = HALT;
        else if (fetch_op >= 4'h5)
          state_d = FETCH2;   // memory ops and jumps carry an address byte
        else
          state_d = EXEC;
      end
      FETCH2: begin
        addr_lo_d = progData_i;
        pc_d      = pc_q + PC_W'(1);
        state_d   = EXEC;
      end
      EXEC: begin
        state_d = FETCH1;
        case (op)
          4'h2, 4'h6: begin
            carry_d = ~notC_i;
            zero_d  = ~notZ_i;
          end
          4'h3, 4'h4, 4'h7, 4'h8: zero_d = ~notZ_i;
          default: ;
        endcase
        if (jump_taken)
          pc_d = target;
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH1;
    endcase
  end

  always_ff @(posedge clk_i or negedge notReset_i) begin
    if (!notReset_i) begin
      state_q   <= FETCH1;
      pc_q      <= '0;
      ir_q      <= '0;
      addr_lo_q <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      addr_lo_q <= addr_lo_d;
      carry_q   <= carry_d;
      zero_q    <= zero_d;
    end
  end

  // Output decode from state and IR. Decoding combinationally lets an
  // asynchronous reset drop the strobes in the same cycle.
  always_comb begin
    loadA_o      = 1'b0;
    dataWe_o     = 1'b0;
    notOeALU_o   = 1'b1;
    S_o          = 3'b000;
    notCarryIn_o = 1'b1;
    operand_o    = '0;
    if (state_q == EXEC) begin
      case (op)
        4'h1, 4'h5: begin            // LITI / LD
          S_o        = 3'b010;
          loadA_o    = 1'b1;
          notOeALU_o = 1'b0;
        end
        4'h2, 4'h6: begin            // ADDI / ADD
          S_o        = 3'b011;
          loadA_o    = 1'b1;
          notOeALU_o = 1'b0;
        end
        4'h3, 4'h7: begin            // CMPI / CMP: flags only
          S_o          = 3'b001;
          notCarryIn_o = 1'b0;
        end
        4'h4, 4'h8: begin            // NORI / NOR
          S_o        = 3'b100;
          loadA_o    = 1'b1;
          notOeALU_o = 1'b0;
        end
        4'h9: begin                  // ST: PASS A onto the bus, RAM captures it
          S_o        = 3'b000;
          notOeALU_o = 1'b0;
          dataWe_o   = 1'b1;
        end
        default: ;
      endcase
      // Opcodes 1-4 use the immediate, 5-8 the RAM word.
      if (op >= 4'h1 && op <= 4'h4)
        operand_o = N'(imm);
      else if (op >= 4'h5 && op <= 4'h8)
        operand_o = dataIn_i;
    end
  end

  assign progAddr_o  = pc_q;
  assign dataAddr_o  = target;
  assign carryFlag_o = carry_q;
  assign zeroFlag_o  = zero_q;
  assign halted_o    = (state_q == HALT);

endmodule

// File: tb/tb_nibbler_control.sv
module tb_nibbler_control;
  localparam int N    = 4;
  localparam int PC_W = 12;

  logic            clk = 1'b0;
  logic            notReset;
  logic [PC_W-1:0] progAddr;
  logic [7:0]      progData;
  logic [PC_W-1:0] dataAddr;
  logic [N-1:0]    dataIn;
  logic            dataWe;
  logic            notCarryIn;
  logic [2:0]      S;
  logic [N-1:0]    operand;
  logic            notOeALU;
  logic            loadA;
  logic            notC;
  logic            notZ;
  logic            carryFlag;
  logic            zeroFlag;
  logic            halted;

  logic [7:0] rom [0:4095];
  assign progData = rom[progAddr];

  always #5 clk = ~clk;

  nibbler_control #(.N(N), .PC_W(PC_W)) dut (
    .clk_i        (clk),
    .notReset_i   (notReset),
    .progAddr_o   (progAddr),
    .progData_i   (progData),
    .dataAddr_o   (dataAddr),
    .dataIn_i     (dataIn),
    .dataWe_o     (dataWe),
    .notCarryIn_o (notCarryIn),
    .S_o          (S),
    .operand_o    (operand),
    .notOeALU_o   (notOeALU),
    .loadA_o      (loadA),
    .notC_i       (notC),
    .notZ_i       (notZ),
    .carryFlag_o  (carryFlag),
    .zeroFlag_o   (zeroFlag),
    .halted_o     (halted)
  );

  int checks   = 0;
  int failures = 0;

  // Instruction-level reference model state.
  logic [11:0] m_pc;
  logic [7:0]  m_lo;
  logic        m_c;
  logic        m_z;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_loadA"}, 32'(loadA), 32'(1'b0));
    chk({tag, "_dataWe"}, 32'(dataWe), 32'(1'b0));
    chk({tag, "_notOe"}, 32'(notOeALU), 32'(1'b1));
    chk({tag, "_code"}, 32'({notCarryIn, S}), 32'(4'b1000));
    chk({tag, "_operand"}, 32'(operand), 32'(0));
  endtask

  task automatic model_reset();
    m_pc = '0;
    m_lo = '0;
    m_c  = 1'b0;
    m_z  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    notReset = 1'b0;
    #1;
    chk("rst_pc", 32'(progAddr), 32'(0));
    chk("rst_daddr", 32'(dataAddr), 32'(0));
    chk("rst_c", 32'(carryFlag), 32'(1'b0));
    chk("rst_z", 32'(zeroFlag), 32'(1'b0));
    chk("rst_halt", 32'(halted), 32'(1'b0));
    chk_idle("rst");
    @(negedge clk);
    notReset = 1'b1;
    model_reset();
  endtask

  // Runs one whole instruction starting at a negedge in FETCH1; ends at the
  // negedge where the following FETCH1 (or HALT) is visible.
  task automatic run_instr(input bit use_rand, input logic nc, input logic nz,
                           input logic [3:0] din);
    logic [7:0]  b1;
    logic [3:0]  op;
    logic [3:0]  code;
    logic        la;
    logic        we;
    logic        taken;
    logic [11:0] tgt;
    chk("f1_addr", 32'(progAddr), 32'(m_pc));
    chk("f1_carry", 32'(carryFlag), 32'(m_c));
    chk("f1_zero", 32'(zeroFlag), 32'(m_z));
    chk("f1_halt", 32'(halted), 32'(1'b0));
    chk_idle("f1");
    b1   = rom[m_pc];
    op   = b1[7:4];
    m_pc = m_pc + 12'd1;
    @(negedge clk);
    if (op >= 4'h5 && op <= 4'hE) begin
      chk("f2_addr", 32'(progAddr), 32'(m_pc));
      chk_idle("f2");
      m_lo = rom[m_pc];
      m_pc = m_pc + 12'd1;
      @(negedge clk);
    end
    if (op == 4'hF) begin
      chk("halt_flag", 32'(halted), 32'(1'b1));
      chk("halt_addr", 32'(progAddr), 32'(m_pc));
      chk_idle("halt");
      return;
    end
    if (use_rand) begin
      nc  = 1'($urandom_range(0, 1));
      nz  = 1'($urandom_range(0, 1));
      din = 4'($urandom_range(0, 15));
    end
    notC   = nc;
    notZ   = nz;
    dataIn = din;
    #1;
    case (op)
      4'h1, 4'h5: code = 4'b1010;
      4'h2, 4'h6: code = 4'b1011;
      4'h3, 4'h7: code = 4'b0001;
      4'h4, 4'h8: code = 4'b1100;
      default:    code = 4'b1000;
    endcase
    la = (op == 4'h1) || (op == 4'h2) || (op == 4'h4) ||
         (op == 4'h5) || (op == 4'h6) || (op == 4'h8);
    we = (op == 4'h9);
    chk("ex_loadA", 32'(loadA), 32'(la));
    chk("ex_dataWe", 32'(dataWe), 32'(we));
    chk("ex_notOe", 32'(notOeALU), 32'(!(la || we)));
    chk("ex_code", 32'({notCarryIn, S}), 32'(code));
    chk("ex_daddr", 32'(dataAddr), 32'({b1[3:0], m_lo}));
    chk("ex_halt", 32'(halted), 32'(1'b0));
    if (op != 4'h9) begin
      if (op >= 4'h1 && op <= 4'h4)
        chk("ex_operand", 32'(operand), 32'(b1[3:0]));
      else if (op >= 4'h5 && op <= 4'h8)
        chk("ex_operand", 32'(operand), 32'(din));
      else
        chk("ex_operand", 32'(operand), 32'(0));
    end
    tgt   = {b1[3:0], m_lo};
    taken = (op == 4'hA) || (op == 4'hB && m_c) || (op == 4'hC && !m_c) ||
            (op == 4'hD && m_z) || (op == 4'hE && !m_z);
    if (taken) m_pc = tgt;
    if (op == 4'h2 || op == 4'h6) begin
      m_c = !nc;
      m_z = !nz;
    end else if (op == 4'h3 || op == 4'h4 || op == 4'h7 || op == 4'h8) begin
      m_z = !nz;
    end
    $display("instr op=%0h pc_next=%03h c=%0d z=%0d", op, m_pc, m_c, m_z);
    @(negedge clk);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
  endtask

  initial begin
    notReset = 1'b0;
    notC     = 1'b1;
    notZ     = 1'b1;
    dataIn   = '0;
    model_reset();
    clear_rom();

    // 1: reset during EXEC of ST drops dataWe immediately, refetch at 0.
    rom[0] = 8'h90;
    rom[1] = 8'h55;
    do_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("t1_we_exec", 32'(dataWe), 32'(1'b1));
    notReset = 1'b0;
    #1;
    chk("t1_we_drop", 32'(dataWe), 32'(1'b0));
    chk("t1_pc_zero", 32'(progAddr), 32'(0));
    @(negedge clk);
    notReset = 1'b1;
    model_reset();
    run_instr(1'b0, 1'b1, 1'b1, 4'h0);

    // 2: LITI 9; ADDI 8 with carry out; JC 0x123 taken.
    clear_rom();
    rom[0] = 8'h19;
    rom[1] = 8'h28;
    rom[2] = 8'hB1;
    rom[3] = 8'h23;
    do_reset();
    run_instr(1'b0, 1'b1, 1'b1, 4'h0);
    run_instr(1'b0, 1'b0, 1'b0, 4'h0);
    chk("t2_carry", 32'(carryFlag), 32'(1'b1));
    run_instr(1'b0, 1'b1, 1'b1, 4'h0);
    chk("t2_jc_target", 32'(progAddr), 32'(12'h123));
    run_instr(1'b0, 1'b1, 1'b1, 4'h0);

    // 3: CMPI equal sets zero only; JNZ not taken.
    clear_rom();
    rom[0] = 8'h15;
    rom[1] = 8'h35;
    rom[2] = 8'hE2;
    rom[3] = 8'h00;
    do_reset();
    run_instr(1'b0, 1'b1, 1'b1, 4'h0);
    run_instr(1'b0, 1'b1, 1'b0, 4'h0);
    chk("t3_zero", 32'(zeroFlag), 32'(1'b1));
    chk("t3_carry", 32'(carryFlag), 32'(1'b0));
    run_instr(1'b0, 1'b1, 1'b1, 4'h0);
    chk("t3_not_taken", 32'(progAddr), 32'(12'h004));

    // 4: ST 0x0A5 then LD 0x0A5 returning 7.
    clear_rom();
    rom[0] = 8'h90;
    rom[1] = 8'hA5;
    rom[2] = 8'h50;
    rom[3] = 8'hA5;
    do_reset();
    run_instr(1'b0, 1'b1, 1'b1, 4'h0);
    run_instr(1'b0, 1'b1, 1'b1, 4'h7);

    // 5: PC wrap at 0xFFF, including an address byte fetched from 0x000.
    clear_rom();
    rom[0]      = 8'hAF;
    rom[1]      = 8'hFF;
    rom[12'hFFF] = 8'h00;
    do_reset();
    run_instr(1'b0, 1'b1, 1'b1, 4'h0);
    run_instr(1'b0, 1'b1, 1'b1, 4'h0);
    chk("t5_wrap", 32'(progAddr), 32'(0));
    rom[12'hFFF] = 8'hA0;
    run_instr(1'b0, 1'b1, 1'b1, 4'h0);
    run_instr(1'b0, 1'b1, 1'b1, 4'h0);
    chk("t5_jmp_wrap", 32'(progAddr), 32'(12'h0AF));
    run_instr(1'b0, 1'b1, 1'b1, 4'h0);

    // 6: HALT freezes PC with no strobes until reset.
    clear_rom();
    rom[0] = 8'hF0;
    do_reset();
    run_instr(1'b0, 1'b1, 1'b1, 4'h0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t6_pc_frozen", 32'(progAddr), 32'(1));
      chk("t6_halted", 32'(halted), 32'(1'b1));
      chk("t6_loadA", 32'(loadA), 32'(1'b0));
      chk("t6_dataWe", 32'(dataWe), 32'(1'b0));
    end
    rom[0] = 8'h00;
    do_reset();
    run_instr(1'b0, 1'b1, 1'b1, 4'h0);

    // Random programs (HALT excluded) with random flags and RAM data.
    for (int i = 0; i < 4096; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      if (b[7:4] == 4'hF) b[7:4] = 4'h0;
      rom[i] = b;
    end
    do_reset();
    for (int i = 0; i < 300; i++)
      run_instr(1'b1, 1'b1, 1'b1, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
